registers_writeback: RTL

Parametrised second-generation register writeback stage for the maxicore32 pipeline. It sits between the memory-access stage and the register file. It decodes LOADI and LOAD instructions and produces a single fully-formed register write, with immediates and loaded data already extended to DATA_WIDTH. It adds three things over the first-generation stage: a valid/ready handshake, a wait state for late memory data with a timeout, and sized/signed load extension.

---
 rtl/registers_writeback_pkg.sv | 36 +++
 rtl/registers_writeback_extend.sv | 46 ++++
 rtl/registers_writeback.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/registers_writeback_pkg.sv
// ---------------------------------------------------------------------------
// registers_writeback_pkg
// Shared types and constants for the maxicore32 register writeback stage.
//   - opcode values used by the stage (LOADI, LOAD, NOP)
//   - t_immediate_type : how a LOADI immediate is widened
//   - t_load_size      : how LOAD read data is narrowed and widened
//   - t_wb_state       : writeback stage FSM states
// ---------------------------------------------------------------------------
package registers_writeback_pkg;

    localparam logic [4:0] OPCODE_NOP   = 5'h00;
    localparam logic [4:0] OPCODE_LOADI = 5'h04;
    localparam logic [4:0] OPCODE_LOAD  = 5'h05;

    localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

    // Encoding 2'b11 is reserved and behaves like IT_UNSIGNED.
    typedef enum logic [1:0] {
        IT_UNSIGNED = 2'b00,
        IT_SIGNED   = 2'b01,
        IT_TOPHALF  = 2'b10
    } t_immediate_type;

    typedef enum logic [1:0] {
        LS_WORD   = 2'b00,
        LS_HALF   = 2'b01,
        LS_BYTE   = 2'b10,
        LS_BYTE_S = 2'b11
    } t_load_size;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_WAIT_MEM = 1'b1
    } t_wb_state;

endpackage

// File: rtl/registers_writeback_extend.sv
// ---------------------------------------------------------------------------
// writeback_extend
// Combinational widening of a register write value to DATA_WIDTH.
//   is_load    in  select load extension (1) or immediate extension (0)
//   sel        in  instruction [25:24]: immediate type or load size
//   immediate  in  16-bit LOADI immediate
//   load_data  in  memory read data, lane-aligned to bit 0
//   ext_value  out widened value
// ---------------------------------------------------------------------------
module writeback_extend
    import registers_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_load,
    input  logic [1:0]            sel,
    input  logic [15:0]           immediate,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] ext_value
);

    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        imm_ext = DATA_WIDTH'(immediate);
        case (sel)
            IT_SIGNED:  imm_ext = DATA_WIDTH'($signed(immediate));
            IT_TOPHALF: imm_ext = DATA_WIDTH'(immediate) << (DATA_WIDTH - 16);
            default:    imm_ext = DATA_WIDTH'(immediate);
        endcase
    end

    always_comb begin
        load_ext = load_data;
        case (sel)
            LS_HALF:   load_ext = DATA_WIDTH'(load_data[15:0]);
            LS_BYTE:   load_ext = DATA_WIDTH'(load_data[7:0]);
            LS_BYTE_S: load_ext = DATA_WIDTH'($signed(load_data[7:0]));
            default:   load_ext = load_data;
        endcase
    end

    assign ext_value = is_load ? load_ext : imm_ext;

endmodule

// File: rtl/registers_writeback.sv
// ---------------------------------------------------------------------------
// registers_writeback
// Writeback stage between memory access and the register file. Turns LOADI
// and LOAD instructions into one fully extended register write, waiting for
// late memory data with a timeout.
//
// Handshake: an instruction transfers on a cycle where inbound_valid and
// inbound_ready are both 1; inbound_ready is 1 exactly while in S_RUN.
// write, bus_error and outbound_valid are single-cycle registered pulses.
//
// Ports:
//   clock, reset (async, active-low)
//   inbound_valid/ready/instruction    upstream handshake
//   data_in, data_in_valid             memory read data
//   write, write_index, write_data     register file write
//   outbound_valid/instruction         to next stage
//   bus_error                          pulse on memory timeout
//   debug_state                        1 while waiting for memory data
// ---------------------------------------------------------------------------
module registers_writeback
    import registers_writeback_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 15,
    localparam int COUNT_WIDTH = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inbound_valid,
    output logic                  inbound_ready,
    input  logic [31:0]           inbound_instruction,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  write,
    output logic [3:0]            write_index,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  outbound_valid,
    output logic [31:0]           outbound_instruction,
    output logic                  bus_error,
    output logic                  debug_state
);

    t_wb_state              state_q, state_d;
    logic [COUNT_WIDTH-1:0] counter_q, counter_d;
    logic [31:0]            pending_q, pending_d;
    logic                   write_q, write_d;
    logic [3:0]             write_index_q, write_index_d;
    logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
    logic                   outbound_valid_q, outbound_valid_d;
    logic [31:0]            outbound_instruction_q, outbound_instruction_d;
    logic                   bus_error_q, bus_error_d;

    logic                   transfer;
    logic [4:0]             in_opcode;
    logic [1:0]             load_sel;
    logic [DATA_WIDTH-1:0]  imm_value;
    logic [DATA_WIDTH-1:0]  load_value;

    assign inbound_ready = (state_q == S_RUN);
    assign transfer      = inbound_valid && inbound_ready;
    assign in_opcode     = inbound_instruction[31:27];

    // While waiting, the load size comes from the latched instruction, since
    // the inbound bus is not guaranteed to still carry it.
    assign load_sel = (state_q == S_WAIT_MEM) ? pending_q[25:24]
                                              : inbound_instruction[25:24];

    writeback_extend #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
        .is_load   (1'b0),
        .sel       (inbound_instruction[25:24]),
        .immediate (inbound_instruction[15:0]),
        .load_data (data_in),
        .ext_value (imm_value)
    );

    writeback_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .is_load   (1'b1),
        .sel       (load_sel),
        .immediate (inbound_instruction[15:0]),
        .load_data (data_in),
        .ext_value (load_value)
    );

    always_comb begin
        state_d                = state_q;
        counter_d              = counter_q;
        pending_d              = pending_q;
        write_d                = 1'b0;
        write_index_d          = write_index_q;
        write_data_d           = write_data_q;
        outbound_valid_d       = 1'b0;
        outbound_instruction_d = NOP_INSTRUCTION;
        bus_error_d            = 1'b0;

        case (state_q)
            S_RUN: begin
                if (transfer) begin
                    if (in_opcode == OPCODE_LOADI) begin
                        write_d                = 1'b1;
                        write_index_d          = inbound_instruction[23:20];
                        write_data_d           = imm_value;
                        outbound_valid_d       = 1'b1;
                        outbound_instruction_d = inbound_instruction;
                    end else if (in_opcode == OPCODE_LOAD) begin
                        if (data_in_valid) begin
                            write_d                = 1'b1;
                            write_index_d          = inbound_instruction[23:20];
                            write_data_d           = load_value;
                            outbound_valid_d       = 1'b1;
                            outbound_instruction_d = inbound_instruction;
                        end else begin
                            pending_d = inbound_instruction;
                            counter_d = '0;
                            state_d   = S_WAIT_MEM;
                        end
                    end else begin
                        outbound_valid_d       = 1'b1;
                        outbound_instruction_d = inbound_instruction;
                    end
                end
            end
            S_WAIT_MEM: begin
                // Data arriving on the final wait cycle takes priority over
                // the timeout.
                if (data_in_valid) begin
                    write_d                = 1'b1;
                    write_index_d          = pending_q[23:20];
                    write_data_d           = load_value;
                    outbound_valid_d       = 1'b1;
                    outbound_instruction_d = pending_q;
                    counter_d              = '0;
                    state_d                = S_RUN;
                end else if (counter_q == COUNT_WIDTH'(MEM_TIMEOUT - 1)) begin
                    bus_error_d = 1'b1;
                    counter_d   = '0;
                    state_d     = S_RUN;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q                <= S_RUN;
            counter_q              <= '0;
            pending_q              <= '0;
            write_q                <= 1'b0;
            write_index_q          <= '0;
            write_data_q           <= '0;
            outbound_valid_q       <= 1'b0;
            outbound_instruction_q <= NOP_INSTRUCTION;
            bus_error_q            <= 1'b0;
        end else begin
            state_q                <= state_d;
            counter_q              <= counter_d;
            pending_q              <= pending_d;
            write_q                <= write_d;
            write_index_q          <= write_index_d;
            write_data_q           <= write_data_d;
            outbound_valid_q       <= outbound_valid_d;
            outbound_instruction_q <= outbound_instruction_d;
            bus_error_q            <= bus_error_d;
        end
    end

    assign write                = write_q;
    assign write_index          = write_index_q;
    assign write_data           = write_data_q;
    assign outbound_valid       = outbound_valid_q;
    assign outbound_instruction = outbound_instruction_q;
    assign bus_error            = bus_error_q;
    assign debug_state          = (state_q == S_WAIT_MEM);

endmodule
